uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Byte-level command controller that sits behind the UART receiver and in front of the UART transmitter. It parses framed register-access commands from the receive byte stream, runs the access on a simple req/ack register bus, and queues a one-byte response for transmission. Inter-byte timeout and error counting let the host resynchronise after line noise or dropped bytes.

## Interface
- CLK_FREQ, 100_000_000, system clock in Hz
- BAUD_RATE, 115200, line rate; sets byte time = 10 × (CLK_FREQ/BAUD_RATE) cycles
- TIMEOUT_BYTES, 4, inter-byte timeout in byte times, range 1..15
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- rx_data  in  8  received byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- bus_req  out  1  register access request, held until bus_ack
- bus_we  out  1  1 = write, 0 = read; stable while bus_req
- bus_addr  out  8  register address; stable while bus_req
- bus_wdata  out  8  write data; stable while bus_req
- bus_ack  in  1  access complete; sampled only while bus_req = 1
- bus_rdata  in  8  read data, valid in the bus_ack cycle of a read
- tx_data  out  8  response byte; stable while tx_valid
- tx_valid  out  1  response available, held until tx_ready
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
- err_cnt  out  8  saturating count of rejected frames/bytes

## Operation
- Frame: SYNC 0xA5, CMD, ADDR, [DATA only when CMD = 0x01], CHK. CHK = XOR of every byte after SYNC and before CHK.
- CMD 0x01 = write, 0x02 = read. Any other CMD is framed as a read (no DATA byte) and answered with NAK.
- States: IDLE → CMD → ADDR → (DATA if write) → CHK → BUS → RESP → IDLE.
- IDLE: every byte other than 0xA5 is discarded silently.
- Each rx_valid in CMD/ADDR/DATA/CHK latches the byte and advances the state.
- At CHK: bad checksum or unknown CMD → skip BUS, go to RESP with 0x15 (NAK), err_cnt +1. Otherwise go to BUS.
- BUS: bus_req = 1. On bus_ack: write → response 0x06 (ACK); read → response bus_rdata captured in the ack cycle.
- RESP: tx_valid = 1 until the tx_valid & tx_ready cycle, then IDLE.
- Timeout: cycle counter cleared on every accepted byte, runs in CMD..CHK. At TIMEOUT_BYTES × byte time → IDLE, no response, err_cnt +1.
- rx_valid during BUS or RESP: byte dropped, err_cnt +1.
- err_cnt saturates at 0xFF and is cleared only by reset.

## Timing
- Reset (rst_n low at an edge): state IDLE; bus_req, bus_we, tx_valid = 0; bus_addr, bus_wdata, tx_data, err_cnt = 0x00; timeout counter 0.
- Byte accepted at edge N → new state visible at N+1.
- bus_req rises one cycle after the CHK byte is accepted. bus_ack may arrive in the first bus_req cycle. bus_req falls the cycle after bus_ack.
- tx_valid rises the cycle after bus_ack, or the cycle after CHK on a NAK. It falls the cycle after the handshake.
- Minimum latency: CHK accept → bus_req, 1 cycle; bus_ack → tx_valid, 1 cycle.
- Timeout and byte arriving in the same cycle: the byte wins and the counter clears.
- No bus timeout: BUS waits for bus_ack indefinitely; only reset exits.

## Configuration
- UART_CMD_CHK_EN defined: CHK byte present and verified as above.
- UART_CMD_CHK_EN undefined: frames carry no CHK byte. The last byte (ADDR for read, DATA for write) goes directly to BUS, or to RESP/NAK for an unknown CMD. Checksum NAK is impossible.

## Structure
- Shared package uart_cmd_pkg holds:
  - constants SYNC_BYTE 0xA5, CMD_WR 0x01, CMD_RD 0x02, RSP_ACK 0x06, RSP_NAK 0x15
  - the state enum
- Sub-module uart_cmd_timeout: loadable down-counter with clear, enable and expire outputs. The parser FSM stays in uart_cmd_ctrl.

## Test plan
- Write: A5 01 10 3C 2D, bus_ack 3 cycles after bus_req → bus_req with we=1, addr 0x10, wdata 0x3C; then tx 0x06; err_cnt 0.
- Read: A5 02 20 22, bus_ack with bus_rdata 0x5A → read of addr 0x20; tx 0x5A.
- Bad checksum A5 01 10 3C 00 → no bus_req; tx 0x15; err_cnt 1. Unknown CMD A5 07 10 17 → tx 0x15; err_cnt 2.
- Noise 00 FF 13, then A5 01, then silence > TIMEOUT_BYTES byte times → no response; err_cnt 1. The next valid write frame completes normally.
- tx_ready held low 20 cycles in RESP while rx_valid pulses → tx_valid/tx_data stable; dropped bytes each increment err_cnt. Also drive 300 errors → err_cnt saturates at 0xFF.
- Reset mid-BUS (rst_n low 1 cycle while bus_req = 1) → all outputs at reset values next cycle; a following frame works.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and parser state encoding for the UART command controller.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_BUS,
    ST_RESP
  } state_t;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_WR) || (c == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: reloads on every received byte, counts down while enabled,
// flags expiry once LIMIT cycles have passed since the last load.
module uart_cmd_timeout #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= W'(LIMIT - 1);
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  assign expired = en && !load && (cnt == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed register-access command parser between UART RX/TX and a req/ack bus.
// Define UART_CMD_CHK_EN to require and verify a trailing XOR checksum byte.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] err_cnt
);

  localparam int BYTE_CYC = 10 * (CLK_FREQ / BAUD_RATE);
  localparam int LIMIT    = TIMEOUT_BYTES * BYTE_CYC;

  state_t     state;
  logic [7:0] cmd;
  logic       parsing, expired, last, chk_ok, frame_ok, err_inc;

  assign parsing = state inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK};

  uart_cmd_timeout #(.LIMIT(LIMIT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rx_valid),
    .en      (parsing),
    .expired (expired)
  );

`ifdef UART_CMD_CHK_EN
  logic [7:0] chk;

  always_ff @(posedge clk) begin
    if (!rst_n)                                                 chk <= '0;
    else if (state == ST_IDLE)                                  chk <= '0;
    else if (rx_valid && state inside {ST_CMD, ST_ADDR, ST_DATA}) chk <= chk ^ rx_data;
  end

  assign last   = (state == ST_CHK);
  assign chk_ok = (rx_data == chk);
`else
  assign last   = (state == ST_DATA) || (state == ST_ADDR && cmd != CMD_WR);
  assign chk_ok = 1'b1;
`endif

  assign frame_ok = cmd_known(cmd) && chk_ok;

  always_comb begin
    err_inc = 1'b0;
    if (parsing) err_inc = rx_valid ? (last && !frame_ok) : expired;
    else if (state == ST_BUS || state == ST_RESP) err_inc = rx_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      err_cnt   <= '0;
    end else begin
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      case (state)
        ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state <= ST_CMD;
        ST_CMD: begin
          if (rx_valid) begin
            cmd   <= rx_data;
            state <= ST_ADDR;
          end else if (expired) state <= ST_IDLE;
        end
        ST_ADDR: begin
          if (rx_valid) begin
            bus_addr <= rx_data;
            state    <= (cmd == CMD_WR) ? ST_DATA : ST_CHK;
          end else if (expired) state <= ST_IDLE;
        end
        ST_DATA: begin
          if (rx_valid) begin
            bus_wdata <= rx_data;
            state     <= ST_CHK;
          end else if (expired) state <= ST_IDLE;
        end
        ST_CHK: if (!rx_valid && expired) state <= ST_IDLE;
        ST_BUS: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            tx_valid <= 1'b1;
            tx_data  <= bus_we ? RSP_ACK : bus_rdata;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // The frame's final byte overrides the per-state advance above.
      if (rx_valid && parsing && last) begin
        if (frame_ok) begin
          state   <= ST_BUS;
          bus_req <= 1'b1;
          bus_we  <= (cmd == CMD_WR);
        end else begin
          state    <= ST_RESP;
          tx_valid <= 1'b1;
          tx_data  <= RSP_NAK;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized self-checking bench for uart_cmd_ctrl against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int TOB      = 4;
  localparam int LIMIT    = TOB * 10 * (CLK_FREQ / BAUD);

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0, bus_rdata = '0;
  logic       rx_valid = 1'b0, bus_ack = 1'b0, tx_ready = 1'b0;
  logic       bus_req, bus_we, tx_valid;
  logic [7:0] bus_addr, bus_wdata, tx_data, err_cnt;

  int n_tests = 0, n_fail = 0, err_m = 0;

  uart_cmd_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .TIMEOUT_BYTES(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic err_bump();
    if (err_m < 255) err_m++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_noise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b);
    end
  endtask

  function automatic bq_t build_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                      input logic [7:0] data, input bit bad);
    bq_t q;
    logic [7:0] x;
    q = {8'hA5, cmd, addr};
    x = cmd ^ addr;
    if (cmd == 8'h01) begin
      q.push_back(data);
      x = x ^ data;
    end
`ifdef UART_CMD_CHK_EN
    q.push_back(bad ? (x ^ 8'h5A) : x);
`else
    if (bad) x = 8'h00;
`endif
    return q;
  endfunction

  function automatic bit has_chk();
`ifdef UART_CMD_CHK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"}, bus_req, 1'b0);
    check({tag, "_txv"}, tx_valid, 1'b0);
    check({tag, "_err"}, err_cnt, err_m[7:0]);
  endtask

  // One complete transaction: frame in, bus access (if legal), response out.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                           input bit bad, input int ack_dly, input logic [7:0] rdata,
                           input int hold, input int drops, input int gap);
    bq_t q;
    bit good;
    logic [7:0] exp_rsp;
    q = build_frame(cmd, addr, data, bad);
    good = (cmd == 8'h01 || cmd == 8'h02) && !(bad && has_chk());
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (i < q.size() - 1) repeat (gap) @(posedge clk);
    end
    if (good) begin
      check("req_rise", bus_req, 1'b1);
      check("txv_bus", tx_valid, 1'b0);
      check("we", bus_we, cmd == 8'h01);
      check("addr", bus_addr, addr);
      if (cmd == 8'h01) check("wdata", bus_wdata, data);
      for (int i = 0; i < ack_dly; i++) begin
        @(posedge clk); #1;
        check("req_hold", bus_req, 1'b1);
      end
      bus_ack = 1'b1; bus_rdata = rdata;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 8'($urandom);
      check("req_fall", bus_req, 1'b0);
      exp_rsp = (cmd == 8'h01) ? 8'h06 : rdata;
    end else begin
      check("nak_noreq", bus_req, 1'b0);
      err_bump();
      exp_rsp = 8'h15;
    end
    check("txv_rise", tx_valid, 1'b1);
    check("tx_data", tx_data, exp_rsp);
    for (int i = 0; i < drops; i++) begin
      send_byte(8'hA5);
      err_bump();
    end
    repeat (hold) @(posedge clk);
    #0;
    check("txv_held", tx_valid, 1'b1);
    check("tx_stable", tx_data, exp_rsp);
    check("err_resp", err_cnt, err_m[7:0]);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("txv_fall", tx_valid, 1'b0);
  endtask

  task automatic rand_frame();
    logic [7:0] c;
    bit bad;
    int kind;
    kind = $urandom_range(0, 3);
    bad = 1'b0;
    case (kind)
      0: c = 8'h01;
      1: c = 8'h02;
      2: begin
        c = 8'($urandom);
        if (c == 8'h01 || c == 8'h02) c = c + 8'h10;
      end
      default: begin
        c = 8'h01;
        bad = has_chk();
      end
    endcase
    send_noise($urandom_range(0, 2));
    run_frame(c, 8'($urandom), 8'($urandom), bad, $urandom_range(0, 4), 8'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2));
  endtask

  initial begin
    bq_t q;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", bus_we, 1'b0);
    check("rst_addr", bus_addr, 8'h00);
    check("rst_wdata", bus_wdata, 8'h00);
    check("rst_txd", tx_data, 8'h00);
    check_idle_outputs("rst");
    rst_n = 1'b1;

    run_frame(8'h01, 8'h10, 8'h3C, 1'b0, 3, 8'h00, 0, 0, 0);
    check("err_after_wr", err_cnt, 8'h00);
    run_frame(8'h02, 8'h20, 8'h00, 1'b0, 0, 8'h5A, 2, 0, 0);
    if (has_chk()) run_frame(8'h01, 8'h10, 8'h3C, 1'b1, 0, 8'h00, 0, 0, 0);
    run_frame(8'h07, 8'h10, 8'h00, 1'b0, 0, 8'h00, 0, 0, 0);

    // Noise, partial frame, then silence past the timeout.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    send_byte(8'hA5); send_byte(8'h01);
    repeat (LIMIT + 20) @(posedge clk);
    #1;
    err_bump();
    check_idle_outputs("tmo");
    run_frame(8'h01, 8'h44, 8'h99, 1'b0, 1, 8'h00, 0, 0, 0);

    // Inter-byte gaps just under the timeout must not abort the frame.
    run_frame(8'h01, 8'h55, 8'hAA, 1'b0, 0, 8'h00, 0, 0, LIMIT - 20);
    run_frame(8'h02, 8'h66, 8'h00, 1'b0, 2, 8'hC3, 20, 3, LIMIT - 20);

    for (int n = 0; n < 40; n++) rand_frame();

    // Reset while a bus access is outstanding.
    q = build_frame(8'h01, 8'h77, 8'h12, 1'b0);
    foreach (q[i]) send_byte(q[i]);
    check("pre_rst_req", bus_req, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    err_m = 0;
    check("mid_rst_we", bus_we, 1'b0);
    check("mid_rst_addr", bus_addr, 8'h00);
    check("mid_rst_wdata", bus_wdata, 8'h00);
    check("mid_rst_txd", tx_data, 8'h00);
    check_idle_outputs("mid_rst");
    run_frame(8'h02, 8'h78, 8'h00, 1'b0, 1, 8'h3E, 0, 0, 0);
    for (int n = 0; n < 8; n++) rand_frame();

    // Saturation: many bytes dropped while a NAK waits in RESP.
    run_frame(8'h33, 8'h01, 8'h00, 1'b0, 0, 8'h00, 0, 300, 0);
    check("err_sat", err_cnt, 8'hFF);
    run_frame(8'h01, 8'h02, 8'h03, 1'b0, 0, 8'h00, 0, 0, 0);
    check("err_sat_hold", err_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
